cover_toggle_scheduler: RTL and testbench

Sequencer between one toggle-coverage hit vector and the single coverage-report channel. It captures per-cycle hit bits, filters out points that were already reported, and serialises each newly covered point as one global cover index over a valid/ready stream. Points are reported lowest bit first. A clear handshake starts a new fuzzing iteration by forgetting all covered points. One instance sits beside each toggle group and feeds the shared coverage-report arbiter.

---
 rtl/cover_toggle_scheduler.sv | 120 ++++++++++++
 tb/tb_cover_toggle_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cover_toggle_scheduler.sv
// cover_toggle_scheduler: serialises newly covered toggle points as global cover indices
module cover_toggle_scheduler #(
    parameter int          WIDTH       = 36,
    parameter logic [63:0] COVER_INDEX = 64'd0,
    parameter logic [63:0] COVER_TOTAL = 64'd38253,
    parameter int          CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_index,
    input  logic             clear_req,
    output logic             clear_done,
    output logic [CNT_W-1:0] covered_cnt
);
    localparam int SEL_W = WIDTH > 1 ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SEND, CLRWAIT, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d, covered_q, covered_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               out_valid_q, out_valid_d, clear_done_q, clear_done_d;
    logic [63:0]        out_index_q, out_index_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   offered, accepted, rest;
    logic               hs, do_clear;

    if (COVER_INDEX + 64'(WIDTH) > COVER_TOTAL) begin : g_range_err
        $error("cover_toggle_scheduler: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    function automatic logic [SEL_W-1:0] lowest(input logic [WIDTH-1:0] v);
        lowest = '0;
        for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) lowest = SEL_W'(i);
    endfunction

    always_comb begin
        offered      = out_valid_q ? (WIDTH'(1) << sel_q) : '0;
        hs           = out_valid_q & out_ready;
        accepted     = hs ? offered : '0;
        rest         = pending_q & ~offered;
        state_d      = state_q;
        sel_d        = sel_q;
        out_valid_d  = out_valid_q;
        out_index_d  = out_index_q;
        clear_done_d = 1'b0;
        do_clear     = 1'b0;
        covered_d    = covered_q | accepted;
        // the offered bit is already in flight, so a repeat hit on it must not re-arm it
        pending_d    = (pending_q | (valid & ~covered_q & ~offered)) & ~accepted;
        cnt_d        = cnt_q + CNT_W'(hs);
        case (state_q)
            IDLE: begin
                if (clear_req) do_clear = 1'b1;
                else if (|pending_q) begin
                    sel_d       = lowest(pending_q);
                    out_index_d = COVER_INDEX + 64'(lowest(pending_q));
                    out_valid_d = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (clear_req && hs) do_clear = 1'b1;
                else if (clear_req) state_d = CLRWAIT;
                else if (hs && |rest) begin
                    sel_d       = lowest(rest);
                    out_index_d = COVER_INDEX + 64'(lowest(rest));
                end else if (hs) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            CLRWAIT: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    state_d     = CLEAR;
                end
            end
            default: do_clear = 1'b1;
        endcase
        if (do_clear) begin
            covered_d    = '0;
            pending_d    = '0;
            cnt_d        = '0;
            out_valid_d  = 1'b0;
            clear_done_d = 1'b1;
            state_d      = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            covered_q    <= '0;
            sel_q        <= '0;
            out_valid_q  <= 1'b0;
            out_index_q  <= '0;
            clear_done_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            covered_q    <= covered_d;
            sel_q        <= sel_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            clear_done_q <= clear_done_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign clear_done  = clear_done_q;
    assign covered_cnt = cnt_q;
endmodule

// File: tb/tb_cover_toggle_scheduler.sv
// tb_cover_toggle_scheduler: scoreboard bench for cover_toggle_scheduler
module tb_cover_toggle_scheduler;
    localparam int W = 36;
    localparam logic [63:0] BASE = 64'd1000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  valid = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_index;
    logic          clear_req = 1'b0;
    logic          clear_done;
    logic [5:0]    covered_cnt;

    int            vectors = 0;
    int            errors = 0;
    logic [63:0]   exp_q[$];

    cover_toggle_scheduler #(.WIDTH(W), .COVER_INDEX(BASE)) dut (
        .clock(clock), .reset(reset), .valid(valid), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index), .clear_req(clear_req),
        .clear_done(clear_done), .covered_cnt(covered_cnt)
    );

    always #5 clock = ~clock;

    // every accepted index must match the oldest expected index
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got %0d required none", out_index);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (out_index !== e) begin
                    errors++;
                    $display("FAIL out_index got %0d required %0d", out_index, e);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    initial begin
        int highs;
        tick(2);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_cnt", 64'(covered_cnt), 0);
        chk("rst_clear_done", 64'(clear_done), 0);
        reset = 1'b0;

        // single hit, latency and repeat suppression
        out_ready = 1'b1;
        valid = W'(1) << 5;
        exp_q.push_back(1005);
        tick();
        valid = '0;
        chk("lat_not_yet", 64'(out_valid), 0);
        tick();
        chk("lat_valid", 64'(out_valid), 1);
        chk("lat_index", out_index, 1005);
        tick();
        chk("single_done", 64'(out_valid), 0);
        chk("single_cnt", 64'(covered_cnt), 1);
        valid = W'(1) << 5;
        tick();
        valid = '0;
        tick(3);
        chk("repeat_cnt", 64'(covered_cnt), 1);

        // three bits, back-to-back without bubbles
        valid = (W'(1) << 35) | (W'(1) << 3) | W'(1);
        exp_q.push_back(1000); exp_q.push_back(1003); exp_q.push_back(1035);
        tick();
        valid = '0;
        tick(); chk("burst_i0", out_index, 1000);
        tick(); chk("burst_i1", out_index, 1003); chk("burst_v1", 64'(out_valid), 1);
        tick(); chk("burst_i2", out_index, 1035); chk("burst_v2", 64'(out_valid), 1);
        tick();
        chk("burst_idle", 64'(out_valid), 0);
        chk("burst_cnt", 64'(covered_cnt), 4);

        // stall with a new hit arriving meanwhile
        out_ready = 1'b0;
        valid = W'(1) << 7;
        tick();
        valid = W'(1) << 2;
        tick();
        valid = '0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", 64'(out_valid), 1);
            chk("stall_index", out_index, 1007);
            if (i < 3) tick();
        end
        exp_q.push_back(1007); exp_q.push_back(1002);
        out_ready = 1'b1;
        tick(); chk("stall_next", out_index, 1002);
        tick();
        chk("stall_cnt", 64'(covered_cnt), 6);

        // clear while stalled in SEND goes through CLRWAIT
        out_ready = 1'b0;
        valid = W'(1) << 9;
        tick();
        valid = '0;
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clrwait_valid", 64'(out_valid), 1);
        chk("clrwait_index", out_index, 1009);
        chk("clrwait_done", 64'(clear_done), 0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clrwait_hold", out_index, 1009);
        exp_q.push_back(1009);
        out_ready = 1'b1;
        tick();
        chk("clrwait_hs_cnt", 64'(covered_cnt), 7);
        chk("clrwait_hs_done", 64'(clear_done), 0);
        chk("clrwait_hs_valid", 64'(out_valid), 0);
        tick();
        chk("clear_pulse", 64'(clear_done), 1);
        chk("clear_cnt", 64'(covered_cnt), 0);
        tick();
        chk("clear_pulse_end", 64'(clear_done), 0);
        valid = (W'(1) << 7) | (W'(1) << 9);
        exp_q.push_back(1007); exp_q.push_back(1009);
        tick();
        valid = '0;
        tick(3);
        chk("after_clear_cnt", 64'(covered_cnt), 2);

        // clear from IDLE takes effect on the sampling edge
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("idle_clear_done", 64'(clear_done), 1);
        chk("idle_clear_cnt", 64'(covered_cnt), 0);

        // every point at once
        valid = '1;
        for (int i = 0; i < W; i++) exp_q.push_back(BASE + 64'(i));
        tick();
        valid = '0;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) highs++;
        end
        chk("all_highs", 64'(highs), 36);
        chk("all_cnt", 64'(covered_cnt), 36);
        chk("all_drained", 64'(exp_q.size()), 0);

        // reset in the middle of a burst
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        valid = W'(6'h3f);
        for (int i = 0; i < 4; i++) exp_q.push_back(BASE + 64'(i));
        tick();
        valid = '0;
        tick(5);
        chk("mid_valid", 64'(out_valid), 1);
        chk("mid_cnt", 64'(covered_cnt), 4);
        chk("mid_index", out_index, 1004);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(out_valid), 0);
        chk("mid_rst_index", out_index, 0);
        chk("mid_rst_cnt", 64'(covered_cnt), 0);
        reset = 1'b0;
        tick(5);
        chk("post_rst_valid", 64'(out_valid), 0);
        chk("final_drained", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running required finished");
        $fatal(1);
    end
endmodule
